// File: rtl/bp_be_stride_pf_table.sv
// Per-PC stride prefetch table: trains strides from observed loads and
// issues degree_p prefetches once an entry's confidence counter saturates.
module bp_be_stride_pf_table
    #(parameter int vaddr_width_p  = 39
    , parameter int sets_p         = 32
    , parameter int ways_p         = 2
    , parameter int tag_width_p    = 10
    , parameter int stride_width_p = 12
    , parameter int ctr_width_p    = 2
    , parameter int degree_p       = 2
    )
    (input  logic                     clk_i
    , input  logic                     reset_i
    , output logic                     init_done_o
    , input  logic                     v_i
    , output logic                     ready_and_o
    , input  logic [vaddr_width_p-1:0] pc_i
    , input  logic [vaddr_width_p-1:0] eaddr_i
    , output logic                     pf_v_o
    , input  logic                     pf_ready_and_i
    , output logic [vaddr_width_p-1:0] pf_addr_o
    , output logic [vaddr_width_p-1:0] pf_pc_o
    );

    localparam int idx_w_lp = $clog2(sets_p);
    localparam int way_w_lp = (ways_p > 1) ? $clog2(ways_p) : 1;
    localparam int k_w_lp   = $clog2(degree_p + 2);

    typedef enum logic [1:0] {e_reset = 2'd0, e_clear = 2'd1, e_run = 2'd2} state_e;

    typedef struct packed {
        logic                      v;
        logic [tag_width_p-1:0]    tag;
        logic [vaddr_width_p-1:0]  prev;
        logic [stride_width_p-1:0] stride;
        logic [ctr_width_p-1:0]    ctr;
    } entry_t;

    typedef entry_t [ways_p-1:0] set_t;

    state_e                state_r;
    logic [idx_w_lp-1:0]   clr_idx_r;
    logic                  init_done_r;

    set_t                  tbl_r [sets_p];
    logic [way_w_lp-1:0]   ptr_r [sets_p];

    logic                  accept_s;
    logic [idx_w_lp-1:0]   idx0_s;
    logic [tag_width_p-1:0] tag0_s;
    set_t                  rd_set_s;
    logic [way_w_lp-1:0]   rd_ptr_s;

    logic                     s1_v_r;
    logic [idx_w_lp-1:0]      s1_idx_r;
    logic [tag_width_p-1:0]   s1_tag_r;
    logic [vaddr_width_p-1:0] s1_pc_r;
    logic [vaddr_width_p-1:0] s1_eaddr_r;
    set_t                     s1_set_r;
    logic [way_w_lp-1:0]      s1_ptr_r;

    logic                      hit_s;
    logic [way_w_lp-1:0]       hit_way_s;
    logic                      inv_s;
    logic [way_w_lp-1:0]       inv_way_s;
    logic [way_w_lp-1:0]       vic_way_s;
    entry_t                    hit_e_s;
    entry_t                    new_e_s;
    logic [vaddr_width_p-1:0]  delta_s;
    logic                      fits_s;
    set_t                      wr_set_s;
    logic [way_w_lp-1:0]       new_ptr_s;
    logic                      trig_s;
    logic [vaddr_width_p-1:0]  stride_ext_s;

    logic                      pf_v_r;
    logic [vaddr_width_p-1:0]  pf_addr_r;
    logic [vaddr_width_p-1:0]  pf_pc_r;
    logic [vaddr_width_p-1:0]  pf_stride_r;
    logic [k_w_lp-1:0]         k_r;

    assign init_done_o = init_done_r;
    assign ready_and_o = init_done_r;
    assign pf_v_o      = pf_v_r;
    assign pf_addr_o   = pf_addr_r;
    assign pf_pc_o     = pf_pc_r;

    assign accept_s = v_i & init_done_r;
    assign idx0_s   = pc_i[1 +: idx_w_lp];
    assign tag0_s   = pc_i[1 + idx_w_lp +: tag_width_p];

    // Mode sequencer: one reset cycle, then one set cleared per cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= e_reset;
            clr_idx_r   <= '0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                e_reset: begin
                    state_r   <= e_clear;
                    clr_idx_r <= '0;
                end
                e_clear: begin
                    clr_idx_r <= clr_idx_r + idx_w_lp'(1);
                    if (clr_idx_r == idx_w_lp'(sets_p - 1)) begin
                        state_r     <= e_run;
                        init_done_r <= 1'b1;
                    end
                end
                e_run: begin
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= e_reset;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Stage-0 read; a set being rewritten by stage 1 is taken from its write data.
    always_comb begin
        if (s1_v_r && (s1_idx_r == idx0_s)) begin
            rd_set_s = wr_set_s;
            rd_ptr_s = new_ptr_s;
        end else begin
            rd_set_s = tbl_r[idx0_s];
            rd_ptr_s = ptr_r[idx0_s];
        end
    end

    // Stage-1 pipeline register holding the accepted load and its set.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_v_r     <= 1'b0;
            s1_idx_r   <= '0;
            s1_tag_r   <= '0;
            s1_pc_r    <= '0;
            s1_eaddr_r <= '0;
            s1_set_r   <= '0;
            s1_ptr_r   <= '0;
        end else begin
            s1_v_r <= accept_s;
            if (accept_s) begin
                s1_idx_r   <= idx0_s;
                s1_tag_r   <= tag0_s;
                s1_pc_r    <= pc_i;
                s1_eaddr_r <= eaddr_i;
                s1_set_r   <= rd_set_s;
                s1_ptr_r   <= rd_ptr_s;
            end
        end
    end

    // Hit search and lowest invalid way; descending loop lets the lowest index win.
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        inv_s     = 1'b0;
        inv_way_s = '0;
        for (int w = ways_p - 1; w >= 0; w--) begin
            if (s1_set_r[w].v && (s1_set_r[w].tag == s1_tag_r)) begin
                hit_s     = 1'b1;
                hit_way_s = way_w_lp'(w);
            end else begin
                hit_s     = hit_s;
            end
            if (!s1_set_r[w].v) begin
                inv_s     = 1'b1;
                inv_way_s = way_w_lp'(w);
            end else begin
                inv_s     = inv_s;
            end
        end
    end

    assign hit_e_s   = s1_set_r[hit_way_s];
    assign vic_way_s = inv_s ? inv_way_s : s1_ptr_r;
    assign delta_s   = s1_eaddr_r - hit_e_s.prev;
    // Delta fits the signed stride when all bits above the stride's sign bit match it.
    assign fits_s    = (&delta_s[vaddr_width_p-1:stride_width_p-1])
                     | ~(|delta_s[vaddr_width_p-1:stride_width_p-1]);

    // Entry update: train on hit, allocate on miss.
    always_comb begin
        new_e_s   = hit_e_s;
        wr_set_s  = s1_set_r;
        new_ptr_s = s1_ptr_r;
        if (hit_s) begin
            new_e_s.prev = s1_eaddr_r;
            if (fits_s && (delta_s[stride_width_p-1:0] == hit_e_s.stride)) begin
                new_e_s.ctr = (&hit_e_s.ctr) ? hit_e_s.ctr : hit_e_s.ctr + ctr_width_p'(1);
            end else begin
                new_e_s.stride = fits_s ? delta_s[stride_width_p-1:0] : '0;
                new_e_s.ctr    = '0;
            end
            wr_set_s[hit_way_s] = new_e_s;
        end else begin
            new_e_s = '{v: 1'b1, tag: s1_tag_r, prev: s1_eaddr_r, stride: '0, ctr: '0};
            wr_set_s[vic_way_s] = new_e_s;
            if (!inv_s && (ways_p > 1)) begin
                new_ptr_s = s1_ptr_r + way_w_lp'(1);
            end else begin
                new_ptr_s = s1_ptr_r;
            end
        end
    end

    assign trig_s       = s1_v_r & hit_s & (&new_e_s.ctr) & (|new_e_s.stride);
    assign stride_ext_s = {{(vaddr_width_p - stride_width_p){new_e_s.stride[stride_width_p-1]}},
                           new_e_s.stride};

    // Table storage: cleared during e_clear, written back from stage 1 in e_run.
    always_ff @(posedge clk_i) begin
        if (state_r == e_clear) begin
            tbl_r[clr_idx_r] <= '0;
            ptr_r[clr_idx_r] <= '0;
        end else if (s1_v_r) begin
            tbl_r[s1_idx_r] <= wr_set_s;
            ptr_r[s1_idx_r] <= new_ptr_s;
        end
    end

    // Prefetch generator: a new trigger always restarts the sequence at k = 1.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pf_v_r      <= 1'b0;
            pf_addr_r   <= '0;
            pf_pc_r     <= '0;
            pf_stride_r <= '0;
            k_r         <= '0;
        end else if (trig_s) begin
            pf_v_r      <= 1'b1;
            pf_addr_r   <= s1_eaddr_r + stride_ext_s;
            pf_pc_r     <= s1_pc_r;
            pf_stride_r <= stride_ext_s;
            k_r         <= k_w_lp'(1);
        end else if (pf_v_r && pf_ready_and_i) begin
            k_r       <= k_r + k_w_lp'(1);
            pf_v_r    <= (k_r != k_w_lp'(degree_p));
            pf_addr_r <= pf_addr_r + pf_stride_r;
        end
    end

endmodule

// File: tb/tb_bp_be_stride_pf_table.sv
// Scoreboard bench for bp_be_stride_pf_table: directed load streams push the
// expected prefetches; a monitor pops and compares on every prefetch handshake.
`timescale 1ns/1ps
module tb_bp_be_stride_pf_table;
    localparam int VW = 39;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          init_done_o;
    logic          v_i = 1'b0;
    logic          ready_and_o;
    logic [VW-1:0] pc_i = '0;
    logic [VW-1:0] eaddr_i = '0;
    logic          pf_v_o;
    logic          pf_ready_and_i = 1'b0;
    logic [VW-1:0] pf_addr_o;
    logic [VW-1:0] pf_pc_o;

    typedef struct packed {
        logic [VW-1:0] addr;
        logic [VW-1:0] pc;
    } exp_t;

    exp_t exp_q [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    bp_be_stride_pf_table #(
        .vaddr_width_p (VW),
        .sets_p        (32),
        .ways_p        (2),
        .tag_width_p   (10),
        .stride_width_p(12),
        .ctr_width_p   (2),
        .degree_p      (2)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .init_done_o    (init_done_o),
        .v_i            (v_i),
        .ready_and_o    (ready_and_o),
        .pc_i           (pc_i),
        .eaddr_i        (eaddr_i),
        .pf_v_o         (pf_v_o),
        .pf_ready_and_i (pf_ready_and_i),
        .pf_addr_o      (pf_addr_o),
        .pf_pc_o        (pf_pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Monitor: every accepted prefetch must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!reset_i && pf_v_o && pf_ready_and_i) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL pf_unexpected: got addr %h pc %h required no prefetch", pf_addr_o, pf_pc_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pf_handshake", {pf_addr_o, pf_pc_o}, {e.addr, e.pc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [VW-1:0] addr, input logic [VW-1:0] pc);
        exp_q.push_back('{addr: addr, pc: pc});
    endtask

    task automatic issue(input logic [VW-1:0] pc, input logic [VW-1:0] ea);
        v_i     = 1'b1;
        pc_i    = pc;
        eaddr_i = ea;
        @(posedge clk);
        #1;
        v_i = 1'b0;
    endtask

    // Loads base + i*stride for i = first .. first+n-1, with gap idle cycles after each.
    task automatic train(input logic [VW-1:0] pc, input logic [VW-1:0] base, input int stride,
                         input int first, input int n, input int gap);
        for (int i = first; i < first + n; i++) begin
            issue(pc, VW'(longint'(base) + longint'(stride) * longint'(i)));
            repeat (gap) step();
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        repeat (8) step();
        check(name, exp_q.size(), 0);
    endtask

    // Reset, check immediate output values, then time init while offering ignored loads.
    task automatic do_reset();
        int  n_done;
        int  n_rdy;
        logic saw_pf;
        reset_i = 1'b1;
        v_i     = 1'b0;
        #1;
        check("rst_pf_v", pf_v_o, 0);
        check("rst_pf_addr", pf_addr_o, 0);
        check("rst_pf_pc", pf_pc_o, 0);
        check("rst_done_ready", {init_done_o, ready_and_o}, 0);
        exp_q.delete();
        repeat (2) step();
        reset_i = 1'b0;
        n_done = 0;
        n_rdy  = 0;
        saw_pf = 1'b0;
        for (int i = 1; i <= 100 && n_done == 0; i++) begin
            v_i     = 1'b1;
            pc_i    = 39'h400;
            eaddr_i = 39'h1000 - VW'(64 * (34 - i));
            @(posedge clk);
            #1;
            if (pf_v_o) saw_pf = 1'b1;
            if (ready_and_o && n_rdy == 0) n_rdy = i;
            if (init_done_o) n_done = i;
        end
        v_i = 1'b0;
        check("init_cycles", n_done, 33);
        check("ready_cycles", n_rdy, 33);
        check("init_no_pf", saw_pf, 0);
    endtask

    initial begin
        #2;
        // Basic training, negative stride, out-of-range jump.
        do_reset();
        pf_ready_and_i = 1'b1;
        train(39'h400, 39'h1000, 64, 0, 4, 3);
        push(39'h1140, 39'h400);
        push(39'h1180, 39'h400);
        train(39'h400, 39'h1000, 64, 4, 1, 3);
        wait_drain("basic_seq");

        train(39'h404, 39'h9000, -16, 0, 4, 3);
        push(39'h8FB0, 39'h404);
        push(39'h8FA0, 39'h404);
        train(39'h404, 39'h9000, -16, 4, 1, 3);
        wait_drain("neg_stride");

        issue(39'h400, 39'h6100);
        repeat (3) step();
        train(39'h400, 39'h6100, 64, 1, 3, 3);
        push(39'h6240, 39'h400);
        push(39'h6280, 39'h400);
        train(39'h400, 39'h6100, 64, 4, 1, 3);
        wait_drain("jump_retrain");

        // Three PCs in set 0: round-robin replacement.
        do_reset();
        pf_ready_and_i = 1'b1;
        train(39'h400, 39'h1000, 64, 0, 4, 3);
        train(39'h800, 39'h2000, 8, 0, 3, 3);
        issue(39'hC00, 39'h3000);
        repeat (3) step();
        issue(39'h400, 39'h1100);
        repeat (3) step();
        issue(39'h800, 39'h2018);
        repeat (3) step();
        train(39'h800, 39'h2018, 8, 1, 3, 3);
        push(39'h2040, 39'h800);
        push(39'h2048, 39'h800);
        train(39'h800, 39'h2018, 8, 4, 1, 3);
        train(39'h400, 39'h1100, 64, 1, 3, 3);
        push(39'h1240, 39'h400);
        push(39'h1280, 39'h400);
        train(39'h400, 39'h1100, 64, 4, 1, 3);
        wait_drain("evict_seq");

        // Back-to-back loads: trigger on the fifth, sixth trigger replaces k=2.
        do_reset();
        pf_ready_and_i = 1'b1;
        push(39'h4028, 39'hA00);
        push(39'h4030, 39'hA00);
        push(39'h4038, 39'hA00);
        train(39'hA00, 39'h4000, 8, 0, 6, 0);
        wait_drain("b2b_seq");

        // Stalled consumer, preemption by a new trigger, then reset mid-sequence.
        do_reset();
        pf_ready_and_i = 1'b0;
        train(39'h400, 39'h1000, 64, 0, 5, 3);
        @(negedge clk);
        check("stall_first", {pf_v_o, pf_addr_o, pf_pc_o}, {1'b1, 39'h1140, 39'h400});
        step();
        for (int i = 0; i < 4; i++) begin
            issue(39'h800, 39'h8000 + VW'(32 * i));
            @(negedge clk);
            check("stall_hold", {pf_v_o, pf_addr_o}, {1'b1, 39'h1140});
            step();
        end
        push(39'h80A0, 39'h800);
        issue(39'h800, 39'h8080);
        @(negedge clk);
        check("preempt_old_held", {pf_v_o, pf_addr_o, pf_pc_o}, {1'b1, 39'h1140, 39'h400});
        @(negedge clk);
        check("preempt_new", {pf_v_o, pf_addr_o, pf_pc_o}, {1'b1, 39'h80A0, 39'h800});
        step();
        pf_ready_and_i = 1'b1;
        step();
        pf_ready_and_i = 1'b0;
        @(negedge clk);
        check("stall_k2", {pf_v_o, pf_addr_o, pf_pc_o}, {1'b1, 39'h80C0, 39'h800});
        check("sb_k1_taken", exp_q.size(), 0);
        #1;
        do_reset();

        // Table rebuilt after reset: the previously trained PC starts from scratch.
        pf_ready_and_i = 1'b1;
        issue(39'h800, 39'h80A0);
        repeat (3) step();
        wait_drain("rebuild");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
